// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts AC snoops, looks the line up in the local cache,
// returns the CR response, streams the line on CD when data is transferred, and
// issues a one-cycle coherence-state update to the cache.
module ace_snoop_responder #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    // AC snoop request
    input  logic                             ac_valid_i,
    output logic                             ac_ready_o,
    input  logic [ADDR_WIDTH-1:0]            ac_addr_i,
    input  logic [3:0]                       ac_snoop_i,
    // CR snoop response
    output logic                             cr_valid_o,
    input  logic                             cr_ready_i,
    output logic [4:0]                       cr_resp_o,
    // CD snoop data
    output logic                             cd_valid_o,
    input  logic                             cd_ready_i,
    output logic [DATA_WIDTH-1:0]            cd_data_o,
    output logic                             cd_last_o,
    // Cache lookup port
    output logic                             lookup_req_o,
    output logic [ADDR_WIDTH-1:0]            lookup_addr_o,
    input  logic                             lookup_valid_i,
    input  logic                             lookup_hit_i,
    input  logic                             lookup_unique_i,
    input  logic                             lookup_dirty_i,
    input  logic [DATA_WIDTH*LINE_BEATS-1:0] lookup_data_i,
    // Cache state update
    output logic                             upd_valid_o,
    output logic [ADDR_WIDTH-1:0]            upd_addr_o,
    output logic                             upd_hit_o,
    output logic                             upd_unique_o,
    output logic                             upd_dirty_o
);

    localparam int unsigned CntW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(LINE_BEATS - 1);

    localparam logic [3:0] SnpReadOnce          = 4'b0000;
    localparam logic [3:0] SnpReadShared        = 4'b0001;
    localparam logic [3:0] SnpReadClean         = 4'b0010;
    localparam logic [3:0] SnpReadNotSharedDirty = 4'b0011;
    localparam logic [3:0] SnpReadUnique        = 4'b0111;
    localparam logic [3:0] SnpCleanShared       = 4'b1000;
    localparam logic [3:0] SnpCleanInvalid      = 4'b1001;
    localparam logic [3:0] SnpMakeInvalid       = 4'b1101;
    localparam logic [3:0] SnpDvmComplete       = 4'b1110;
    localparam logic [3:0] SnpDvmMessage        = 4'b1111;

    typedef enum logic [1:0] {StIdle, StLookup, StResp, StData} state_e;

    state_e                               state_q, state_d;
    logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
    logic [3:0]                           snoop_q, snoop_d;
    logic [4:0]                           resp_q, resp_d;
    logic [LINE_BEATS-1:0][DATA_WIDTH-1:0] line_q, line_d;
    logic [CntW-1:0]                      cnt_q, cnt_d;
    logic                                 upd_pend_q, upd_pend_d;
    logic                                 upd_hit_q, upd_hit_d;
    logic                                 upd_unique_q, upd_unique_d;
    logic                                 upd_dirty_q, upd_dirty_d;

    // State and captured-transaction registers; reset abandons any in-flight snoop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            snoop_q      <= '0;
            resp_q       <= '0;
            line_q       <= '0;
            cnt_q        <= '0;
            upd_pend_q   <= 1'b0;
            upd_hit_q    <= 1'b0;
            upd_unique_q <= 1'b0;
            upd_dirty_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            snoop_q      <= snoop_d;
            resp_q       <= resp_d;
            line_q       <= line_d;
            cnt_q        <= cnt_d;
            upd_pend_q   <= upd_pend_d;
            upd_hit_q    <= upd_hit_d;
            upd_unique_q <= upd_unique_d;
            upd_dirty_q  <= upd_dirty_d;
        end
    end

    // Next-state, response computation and output decode.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        snoop_d      = snoop_q;
        resp_d       = resp_q;
        line_d       = line_q;
        cnt_d        = cnt_q;
        upd_pend_d   = upd_pend_q;
        upd_hit_d    = upd_hit_q;
        upd_unique_d = upd_unique_q;
        upd_dirty_d  = upd_dirty_q;

        ac_ready_o    = 1'b0;
        cr_valid_o    = 1'b0;
        cr_resp_o     = '0;
        cd_valid_o    = 1'b0;
        cd_data_o     = '0;
        cd_last_o     = 1'b0;
        lookup_req_o  = 1'b0;
        lookup_addr_o = addr_q;
        upd_valid_o   = 1'b0;
        upd_addr_o    = '0;
        upd_hit_o     = 1'b0;
        upd_unique_o  = 1'b0;
        upd_dirty_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                ac_ready_o = 1'b1;
                if (ac_valid_i) begin
                    addr_d     = ac_addr_i;
                    snoop_d    = ac_snoop_i;
                    resp_d     = '0;
                    upd_pend_d = 1'b0;
                    case (ac_snoop_i)
                        SnpReadOnce, SnpReadShared, SnpReadClean, SnpReadNotSharedDirty,
                        SnpReadUnique, SnpCleanShared, SnpCleanInvalid,
                        SnpMakeInvalid: state_d = StLookup;
                        SnpDvmComplete, SnpDvmMessage: state_d = StResp;
                        default: begin
                            resp_d  = 5'b00010;
                            state_d = StResp;
                        end
                    endcase
                end
            end

            StLookup: begin
                lookup_req_o = 1'b1;
                if (lookup_valid_i) begin
                    line_d       = lookup_data_i;
                    state_d      = StResp;
                    resp_d       = '0;
                    upd_pend_d   = 1'b0;
                    upd_hit_d    = 1'b0;
                    upd_unique_d = 1'b0;
                    upd_dirty_d  = 1'b0;
                    // resp = {WasUnique, IsShared, PassDirty, Error, DataTransfer}
                    if (lookup_hit_i) begin
                        case (snoop_q)
                            SnpReadOnce: begin
                                resp_d = {lookup_unique_i, 1'b1, 1'b0, 1'b0, 1'b1};
                            end
                            SnpReadShared, SnpReadClean, SnpReadNotSharedDirty: begin
                                resp_d     = {lookup_unique_i, 1'b1, lookup_dirty_i, 1'b0, 1'b1};
                                upd_pend_d = 1'b1;
                                upd_hit_d  = 1'b1;
                            end
                            SnpReadUnique: begin
                                resp_d     = {lookup_unique_i, 1'b0, lookup_dirty_i, 1'b0, 1'b1};
                                upd_pend_d = 1'b1;
                            end
                            SnpCleanInvalid: begin
                                resp_d     = {lookup_unique_i, 1'b0, lookup_dirty_i, 1'b0,
                                              lookup_dirty_i};
                                upd_pend_d = 1'b1;
                            end
                            SnpMakeInvalid: begin
                                resp_d     = {lookup_unique_i, 4'b0000};
                                upd_pend_d = 1'b1;
                            end
                            SnpCleanShared: begin
                                resp_d       = {lookup_unique_i, 1'b1, lookup_dirty_i, 1'b0,
                                                lookup_dirty_i};
                                // Only a dirty line needs its state changed.
                                upd_pend_d   = lookup_dirty_i;
                                upd_hit_d    = 1'b1;
                                upd_unique_d = lookup_unique_i;
                            end
                            default: resp_d = '0;
                        endcase
                    end
                end
            end

            StResp: begin
                cr_valid_o = 1'b1;
                cr_resp_o  = resp_q;
                if (cr_ready_i) begin
                    upd_valid_o  = upd_pend_q;
                    upd_addr_o   = upd_pend_q ? addr_q : '0;
                    upd_hit_o    = upd_pend_q & upd_hit_q;
                    upd_unique_o = upd_pend_q & upd_unique_q;
                    upd_dirty_o  = upd_pend_q & upd_dirty_q;
                    upd_pend_d   = 1'b0;
                    if (resp_q[0]) begin
                        state_d = StData;
                        cnt_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            StData: begin
                cd_valid_o = 1'b1;
                cd_data_o  = line_q[cnt_q];
                cd_last_o  = (cnt_q == LastBeat);
                if (cd_ready_i) begin
                    if (cnt_q == LastBeat) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder: a transaction-level model predicts each
// snoop's CR response, state update and CD beats; one negedge process compares.
module tb_ace_snoop_responder;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned LB = 4;
    localparam int unsigned LW = DW * LB;

    localparam logic [3:0] OpReadOnce     = 4'b0000;
    localparam logic [3:0] OpReadShared   = 4'b0001;
    localparam logic [3:0] OpReadUnique   = 4'b0111;
    localparam logic [3:0] OpCleanShared  = 4'b1000;
    localparam logic [3:0] OpCleanInvalid = 4'b1001;
    localparam logic [3:0] OpMakeInvalid  = 4'b1101;
    localparam logic [3:0] OpDvmMessage   = 4'b1111;
    localparam logic [3:0] OpIllegal      = 4'b0101;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          ac_valid_i, ac_ready_o;
    logic [AW-1:0] ac_addr_i;
    logic [3:0]    ac_snoop_i;
    logic          cr_valid_o, cr_ready_i;
    logic [4:0]    cr_resp_o;
    logic          cd_valid_o, cd_ready_i, cd_last_o;
    logic [DW-1:0] cd_data_o;
    logic          lookup_req_o, lookup_valid_i;
    logic [AW-1:0] lookup_addr_o;
    logic          lookup_hit_i, lookup_unique_i, lookup_dirty_i;
    logic [LW-1:0] lookup_data_i;
    logic          upd_valid_o, upd_hit_o, upd_unique_o, upd_dirty_o;
    logic [AW-1:0] upd_addr_o;

    ace_snoop_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LINE_BEATS (LB)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .ac_valid_i      (ac_valid_i),
        .ac_ready_o      (ac_ready_o),
        .ac_addr_i       (ac_addr_i),
        .ac_snoop_i      (ac_snoop_i),
        .cr_valid_o      (cr_valid_o),
        .cr_ready_i      (cr_ready_i),
        .cr_resp_o       (cr_resp_o),
        .cd_valid_o      (cd_valid_o),
        .cd_ready_i      (cd_ready_i),
        .cd_data_o       (cd_data_o),
        .cd_last_o       (cd_last_o),
        .lookup_req_o    (lookup_req_o),
        .lookup_addr_o   (lookup_addr_o),
        .lookup_valid_i  (lookup_valid_i),
        .lookup_hit_i    (lookup_hit_i),
        .lookup_unique_i (lookup_unique_i),
        .lookup_dirty_i  (lookup_dirty_i),
        .lookup_data_i   (lookup_data_i),
        .upd_valid_o     (upd_valid_o),
        .upd_addr_o      (upd_addr_o),
        .upd_hit_o       (upd_hit_o),
        .upd_unique_o    (upd_unique_o),
        .upd_dirty_o     (upd_dirty_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          lookup;
        logic [4:0]    resp;
        logic          upd;
        logic [2:0]    st;   // {hit, unique, dirty}
    } model_t;

    typedef struct packed {
        logic [4:0]    resp;
        logic          upd;
        logic [AW-1:0] addr;
        logic [2:0]    st;
    } exp_cr_t;

    exp_cr_t     exp_cr[$];
    logic [DW:0] exp_cd[$];   // {last, data}

    int n_pass = 0;
    int n_total = 0;

    // Scenario controls shared with the driver and compare processes.
    int          cr_stall = 0, cr_stall_cnt = 0, cd_mode = 0, lk_delay = 0, lk_wait = 0;
    logic        allow_lookup = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    int          beats_seen = 0, upd_seen = 0, lookup_seen = 0;
    logic [4:0]  last_cr_resp = '0;
    logic [2:0]  last_upd = '0;
    logic [DW-1:0] last_cd_data = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic miss(input string name);
        n_total++;
        $display("FAIL %s: event occurred with no matching expectation", name);
    endtask

    // Snoop semantics from the protocol rules: what the cache must answer and become.
    function automatic model_t model(input logic [3:0] op, input logic h, u, d);
        model_t m;
        logic dt, is, pd;
        m = '0;
        dt = 1'b0; is = 1'b0; pd = 1'b0;
        case (op)
            4'b1110, 4'b1111: m.lookup = 1'b0;
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1000, 4'b1001, 4'b1101: begin
                m.lookup = 1'b1;
                if (h) begin
                    if (op == 4'b0000) begin
                        dt = 1; is = 1;
                    end else if (op inside {4'b0001, 4'b0010, 4'b0011}) begin
                        dt = 1; is = 1; pd = d; m.upd = 1; m.st = 3'b100;
                    end else if (op == 4'b0111) begin
                        dt = 1; pd = d; m.upd = 1; m.st = 3'b000;
                    end else if (op == 4'b1001) begin
                        dt = d; pd = d; m.upd = 1; m.st = 3'b000;
                    end else if (op == 4'b1101) begin
                        m.upd = 1; m.st = 3'b000;
                    end else begin
                        dt = d; pd = d; is = 1; m.upd = d; m.st = {1'b1, u, 1'b0};
                    end
                    m.resp = {u, is, pd, 1'b0, dt};
                end
            end
            default: m.resp = 5'b00010;
        endcase
        return m;
    endfunction

    // Lookup responder: answers lk_delay cycles after the request rises.
    initial begin
        lookup_valid_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (lookup_req_o) begin
                lookup_valid_i = (lk_wait >= lk_delay);
                lk_wait++;
            end else begin
                lookup_valid_i = 1'b0;
                lk_wait = 0;
            end
        end
    end

    // CR/CD ready drivers.
    initial begin
        cr_ready_i = 1'b1;
        cd_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (cr_valid_o && cr_stall_cnt < cr_stall) begin
                cr_ready_i = 1'b0;
                cr_stall_cnt++;
            end else begin
                cr_ready_i = 1'b1;
            end
            case (cd_mode)
                1: cd_ready_i = ~cd_ready_i;
                2: cd_ready_i = 1'b0;
                default: cd_ready_i = 1'b1;
            endcase
        end
    end

    // Compare process: checks every handshake and hold condition against the model queues.
    initial begin
        exp_cr_t     e;
        logic [DW:0] b;
        logic        prev_cr_pend, prev_cd_pend;
        logic [4:0]  prev_resp;
        logic [DW:0] prev_cd;
        prev_cr_pend = 1'b0;
        prev_cd_pend = 1'b0;
        prev_resp = '0;
        prev_cd = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev_cr_pend = 1'b0;
                prev_cd_pend = 1'b0;
            end else begin
                if (prev_cr_pend)
                    chk("cr_hold", 128'({cr_valid_o, cr_resp_o}), 128'({1'b1, prev_resp}));
                if (prev_cd_pend)
                    chk("cd_hold", 128'({cd_valid_o, cd_last_o, cd_data_o}),
                        128'({1'b1, prev_cd}));
                if (!allow_lookup) chk("no_lookup", 128'(lookup_req_o), 128'(0));
                if (lookup_req_o) begin
                    lookup_seen++;
                    chk("lookup_addr", 128'(lookup_addr_o), 128'(cur_addr));
                end
                if (cr_valid_o || cd_valid_o || lookup_req_o)
                    chk("ac_ready_busy", 128'(ac_ready_o), 128'(0));
                if (cr_valid_o && cr_ready_i) begin
                    if (exp_cr.size() == 0) begin
                        miss("cr_unexpected");
                    end else begin
                        e = exp_cr.pop_front();
                        chk("cr_resp", 128'(cr_resp_o), 128'(e.resp));
                        chk("upd_valid", 128'(upd_valid_o), 128'(e.upd));
                        if (e.upd)
                            chk("upd_state",
                                128'({upd_addr_o, upd_hit_o, upd_unique_o, upd_dirty_o}),
                                128'({e.addr, e.st}));
                    end
                    last_cr_resp = cr_resp_o;
                end else if (upd_valid_o) begin
                    miss("upd_without_cr");
                end
                if (upd_valid_o) begin
                    upd_seen++;
                    last_upd = {upd_hit_o, upd_unique_o, upd_dirty_o};
                end
                if (cd_valid_o) chk("cd_after_cr", 128'(exp_cr.size()), 128'(0));
                if (cd_valid_o && cd_ready_i) begin
                    if (exp_cd.size() == 0) begin
                        miss("cd_unexpected");
                    end else begin
                        b = exp_cd.pop_front();
                        chk("cd_beat", 128'({cd_last_o, cd_data_o}), 128'(b));
                    end
                    beats_seen++;
                    last_cd_data = cd_data_o;
                end
                prev_cr_pend = cr_valid_o && !cr_ready_i;
                prev_resp    = cr_resp_o;
                prev_cd_pend = cd_valid_o && !cd_ready_i;
                prev_cd      = {cd_last_o, cd_data_o};
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk_i);
        while (!(exp_cr.size() == 0 && exp_cd.size() == 0 && ac_ready_o) && n < 200) begin
            n++;
            @(negedge clk_i);
        end
        if (n >= 200) miss("idle_timeout");
        allow_lookup = 1'b0;
    endtask

    task automatic run_snoop(input logic [AW-1:0] addr, input logic [3:0] op,
                             input logic h, input logic u, input logic d,
                             input logic [LW-1:0] line, input int stall, input int cdm,
                             input int lkd, input bit check_lat, input bit wait_done);
        model_t  m;
        exp_cr_t e;
        int      n;
        m = model(op, h, u, d);
        lookup_hit_i = h; lookup_unique_i = u; lookup_dirty_i = d; lookup_data_i = line;
        lk_delay = lkd; cr_stall = stall; cr_stall_cnt = 0; cd_mode = cdm;
        allow_lookup = m.lookup; cur_addr = addr;
        beats_seen = 0; upd_seen = 0; lookup_seen = 0;
        e.resp = m.resp; e.upd = m.upd; e.addr = addr; e.st = m.st;
        exp_cr.push_back(e);
        if (m.resp[0])
            for (int i = 0; i < int'(LB); i++)
                exp_cd.push_back({(i == int'(LB) - 1), line[i*DW +: DW]});

        @(posedge clk_i);
        #1;
        ac_valid_i = 1'b1; ac_addr_i = addr; ac_snoop_i = op;
        n = 0;
        @(negedge clk_i);
        while (!ac_ready_o && n < 50) begin
            n++;
            @(negedge clk_i);
        end
        if (!ac_ready_o) begin
            miss("ac_accept_timeout");
            ac_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        ac_valid_i = 1'b0;
        if (check_lat) begin
            @(negedge clk_i);
            chk("lat_lookup_c1", 128'({lookup_req_o, cr_valid_o}), 128'(2'b10));
            @(negedge clk_i);
            chk("lat_cr_c2", 128'(cr_valid_o), 128'(1));
        end
        if (wait_done) wait_idle();
    endtask

    initial begin
        int n;
        rst_ni = 1'b0;
        ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = '0;
        lookup_hit_i = 1'b0; lookup_unique_i = 1'b0; lookup_dirty_i = 1'b0;
        lookup_data_i = '0;
        #2;
        chk("reset_valids", 128'({ac_ready_o, cr_valid_o, cd_valid_o, lookup_req_o,
                                  upd_valid_o, cd_last_o}), 128'(6'b100000));
        chk("reset_data", 128'({cr_resp_o, cd_data_o, lookup_addr_o, upd_addr_o,
                                upd_hit_o, upd_unique_o, upd_dirty_o}), 128'(0));
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // 1: ReadShared to UD line, full-speed
        run_snoop(64'h1000, OpReadShared, 1, 1, 1, {64'h3, 64'h2, 64'h1, 64'h0},
                  0, 0, 0, 1, 1);
        chk("t1_resp", 128'(last_cr_resp), 128'(5'b11101));
        chk("t1_upd", 128'({upd_seen, last_upd}), 128'({32'd1, 3'b100}));
        chk("t1_beats", 128'({beats_seen, last_cd_data}), 128'({32'd4, 64'h3}));

        // 2: CleanInvalid to SC line
        run_snoop(64'h2040, OpCleanInvalid, 1, 0, 0, {4{64'h5555}}, 0, 0, 0, 0, 1);
        chk("t2_resp", 128'(last_cr_resp), 128'(5'b00000));
        chk("t2_upd", 128'({upd_seen, last_upd, beats_seen}), 128'({32'd1, 3'b000, 32'd0}));

        // 3: ReadUnique miss
        run_snoop(64'h3080, OpReadUnique, 0, 0, 0, {4{64'h7777}}, 0, 0, 1, 0, 1);
        chk("t3_quiet", 128'({last_cr_resp, upd_seen, beats_seen}), 128'(0));

        // 4: illegal code
        run_snoop(64'h40c0, OpIllegal, 1, 1, 1, {4{64'h9999}}, 0, 0, 0, 0, 1);
        chk("t4_resp", 128'({last_cr_resp, lookup_seen}), 128'({5'b00010, 32'd0}));

        // 5: DVMMessage
        run_snoop(64'h5100, OpDvmMessage, 1, 1, 1, {4{64'h9999}}, 0, 0, 0, 0, 1);
        chk("t5_resp", 128'({last_cr_resp, lookup_seen}), 128'(0));

        // 6a: backpressure on CR and CD, slow lookup
        run_snoop(64'h6140, OpReadUnique, 1, 1, 1,
                  {64'hd3d3, 64'hc2c2, 64'hb1b1, 64'ha0a0}, 3, 1, 2, 0, 1);
        chk("t6_resp", 128'({last_cr_resp, beats_seen}), 128'({5'b10101, 32'd4}));
        run_snoop(64'h7180, OpCleanShared, 1, 0, 1,
                  {64'h44, 64'h33, 64'h22, 64'h11}, 2, 1, 0, 0, 1);
        run_snoop(64'h71c0, OpCleanShared, 1, 1, 0, {4{64'h1}}, 0, 0, 0, 0, 1);
        run_snoop(64'h7200, OpMakeInvalid, 1, 1, 1, {4{64'h2}}, 0, 1, 1, 0, 1);
        run_snoop(64'h7240, OpReadOnce, 1, 0, 1, {64'h8, 64'h7, 64'h6, 64'h5},
                  1, 1, 0, 0, 1);

        // 6b: reset in the middle of DATA
        run_snoop(64'h8280, OpReadShared, 1, 0, 0, {64'hf4, 64'hf3, 64'hf2, 64'hf1},
                  0, 2, 0, 0, 0);
        n = 0;
        @(negedge clk_i);
        while (!cd_valid_o && n < 50) begin
            n++;
            @(negedge clk_i);
        end
        chk("t6b_in_data", 128'(cd_valid_o), 128'(1));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6b_rst_valids", 128'({ac_ready_o, cr_valid_o, cd_valid_o, lookup_req_o,
                                    upd_valid_o}), 128'(5'b10000));
        exp_cr.delete();
        exp_cd.delete();
        allow_lookup = 1'b0;
        cd_mode = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("t6b_after_rst", 128'({ac_ready_o, cr_valid_o, cd_valid_o, cd_data_o}),
            128'({1'b1, 2'b00, 64'h0}));

        // Recovery after reset
        run_snoop(64'h92c0, OpReadOnce, 1, 1, 0, {64'hb, 64'ha, 64'h9, 64'h8},
                  0, 0, 0, 1, 1);
        chk("t7_resp", 128'({last_cr_resp, upd_seen, beats_seen}),
            128'({5'b11001, 32'd0, 32'd4}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
